testpulse_gen: RTL

Programmable test-pulse generator driven by the 32-bit control word of the front-end control/status register, with its 32-bit status word returned to that register's read-back input. It emits bursts or continuous trains of fixed-width pulses on `pulse_o` to inject test signals into the digitizer channels. All logic runs on the Wishbone clock.

---
 rtl/testpulse_gen_if.sv | 10 +
 rtl/testpulse_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/testpulse_gen_if.sv
// Control/status bundle between the front-end CSR block and the test-pulse generator.
// The CSR side owns the control word; the generator owns the status word and the pulse line.
interface testpulse_gen_if;
   logic [31:0] ctrl;
   logic [31:0] status;
   logic        pulse;

   modport master (output ctrl, input status, input pulse);
   modport slave  (input ctrl, output status, output pulse);
endinterface

// File: rtl/testpulse_gen.sv
// Programmable test-pulse generator: bursts or continuous trains of W-cycle pulses
// spaced max(P, W+1) cycles apart, with a wrapping pulse counter reported in the status word.
module testpulse_gen #(
   parameter int CNT_W = 24
) (
   input  logic           wb_clk,
   input  logic           wb_rst,
   testpulse_gen_if.slave bus,
   output logic [1:0]     dbg_state
);

   // ctrl is a quasi-static register (no valid/ready): enable and clear are levels
   // sampled every cycle, all other fields are captured only at launch.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e           state;
   logic [3:0]       w_m1;
   logic [15:0]      pe_m1;
   logic [7:0]       n_q;
   logic [7:0]       rem;
   logic [15:0]      el;
   logic [CNT_W-1:0] cnt;
   logic             pulse;
   logic             busy;
   logic             done;

   logic             en;
   logic             clr;
   logic [15:0]      p_m1_in;
   logic [15:0]      w_in;
   logic [15:0]      pe_m1_in;
   logic             period_end;
   logic             burst_over;
   logic             start;
   logic [23:0]      cnt24;
   logic             unused_bits;

   assign en          = bus.ctrl[0];
   assign clr         = bus.ctrl[2];
   assign unused_bits = ^{bus.ctrl[3], bus.ctrl[1]};

   // Pe-1 = max(P-1, W) guarantees at least one low cycle after every pulse.
   assign p_m1_in  = bus.ctrl[23:8];
   assign w_in     = {12'd0, bus.ctrl[7:4]} + 16'd1;
   assign pe_m1_in = (p_m1_in >= w_in) ? p_m1_in : w_in;

   assign period_end = (el == pe_m1);
   assign burst_over = (n_q != 8'd0) && (rem == 8'd0);

   assign start = ((state == S_IDLE) && en) ||
                  ((state == S_LOW) && en && period_end && !burst_over);

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state <= S_IDLE;
         w_m1  <= '0;
         pe_m1 <= '0;
         n_q   <= '0;
         rem   <= '0;
         el    <= '0;
         pulse <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en) begin
                  w_m1  <= bus.ctrl[7:4];
                  pe_m1 <= pe_m1_in;
                  n_q   <= bus.ctrl[31:24];
                  rem   <= bus.ctrl[31:24] - 8'd1;
                  el    <= '0;
                  pulse <= 1'b1;
                  busy  <= 1'b1;
                  state <= S_HIGH;
               end
            end

            S_HIGH: begin
               el <= el + 16'd1;
               // A pulse always runs its full width; enable is only looked at as it ends.
               if (el == {12'd0, w_m1}) begin
                  pulse <= 1'b0;
                  if (en) begin
                     state <= S_LOW;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end

            S_LOW: begin
               if (!en) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (period_end) begin
                  if (burst_over) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     el    <= '0;
                     rem   <= rem - 8'd1;
                     pulse <= 1'b1;
                     state <= S_HIGH;
                  end
               end else begin
                  el <= el + 16'd1;
               end
            end

            S_DONE: begin
               if (!en) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            default: begin
               pulse <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Clear is a level and beats a pulse start in the same cycle.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= cnt + 1'b1;
      end
   end

   generate
      if (CNT_W >= 24) begin : g_cnt_trunc
         assign cnt24 = cnt[23:0];
      end else begin : g_cnt_ext
         assign cnt24 = {{(24 - CNT_W){1'b0}}, cnt};
      end
   endgenerate

   assign bus.status = {cnt24, 6'd0, done, busy};
   assign bus.pulse  = pulse;
   assign dbg_state  = state;

endmodule
